capture_align_ctrl: RTL
=======================

# capture_align_ctrl

Per-lane input-delay training controller for the DDR LVDS capture path. After a start request it resets the lane IDELAYs and sweeps each lane's tap. At every tap it compares the lane's two captured bits against a known training pattern, finds the first contiguous passing window, and parks the lane at the window centre. It sits beside the DDR capture block: it drives that block's IDELAY control and reads its registered output.

## Interface
- WIDTH, 7: number of LVDS data lanes; the captured word is 2*WIDTH bits.
- TAPS, 32: IDELAY taps per lane. TAP_W = clog2(TAPS).
- SETTLE, 16: idle cycles after any delay change before checking. Covers the capture pipeline depth (2) plus margin.
- CHECK_LEN, 64: consecutive matching samples required for a tap to pass.
- MIN_WIN, 4: minimum window width in taps; a narrower window fails the lane.
- clk  in  1  capture-domain clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a full training run.
- pattern  in  2*WIDTH  expected capture word; held static during a run.
- cap_data  in  2*WIDTH  registered output of the capture block.
- dly_rst  out  1  one-cycle pulse; resets all lane delays to tap 0.
- dly_ce  out  WIDTH  per-lane one-cycle tap-step enable; at most one bit set.
- dly_inc  out  1  step direction: 1 = increment, 0 = decrement.
- busy  out  1  high from accepted start until done.
- done  out  1  level; high once a run completes, cleared by the next accepted start.
- fail_mask  out  WIDTH  bit i set if lane i found no valid window.
- tap_rd_lane  in  clog2(WIDTH)  lane select for readback.
- tap_rd  out  TAP_W  final tap of the selected lane; combinational read of the tap table.

## Operation
- States: IDLE, DRST, SETTLE, CHECK, STEP, CENTER, NEXT, DONE.
- IDLE/DONE:
  - start → DRST: assert dly_rst for 1 cycle.
  - Clear fail_mask, the tap table, lane=0, cur=0, and all window registers.
- DRST → SETTLE.
- SETTLE:
  - Count SETTLE cycles, then go to the state recorded on entry: CHECK during the sweep, CENTER during the walk back.
- CHECK: lane bits are cap_data[2*lane+1:2*lane] versus pattern[2*lane+1:2*lane].
  - Tap passes after CHECK_LEN consecutive matches.
  - The first mismatch fails the tap immediately; remaining samples are not taken.
- Window tracking:
  - On the first pass, set first=cur and last=cur.
  - On each further pass, set last=cur.
  - On a fail after at least one pass, the window is closed.
- Sweep:
  - If the window is not closed and cur<TAPS-1 → STEP: dly_ce[lane]=1, dly_inc=1 for 1 cycle, cur+1, → SETTLE.
  - If the window is closed or cur==TAPS-1 → evaluate.
- Evaluate:
  - No pass, or (last-first+1)<MIN_WIN: set fail_mask[lane], store tap=cur, → NEXT. The lane is left at its current tap.
  - Otherwise compute centre = (first+last)>>1, using a TAP_W+1-bit sum and floor.
- CENTER:
  - While cur>centre: dly_ce[lane]=1, dly_inc=0, cur-1, then SETTLE. No check is made after a decrement.
  - When cur==centre: store tap=centre, → NEXT.
- NEXT: lane+1 with cur=0 → CHECK. No settle is needed; the earlier reset covers it. After lane WIDTH-1 → DONE.
- DONE: busy=0, done=1.
- start while busy is ignored.
- rst at any point: return to IDLE, all outputs 0, tap table cleared. The delay lines are not touched; the next run resets them.

## Timing
- Reset values: dly_rst=0, dly_ce=0, dly_inc=0, busy=0, done=0, fail_mask=0, tap table all 0.
- All outputs are registered except tap_rd.
- start→dly_rst: 1 cycle.
- dly_ce pulses are exactly 1 cycle wide. Each is followed by SETTLE+1 cycles before the first compared sample. There are no back-to-back pulses.
- A passing tap costs CHECK_LEN cycles of CHECK plus SETTLE+2 for the step.
- dly_inc is stable on the cycle dly_ce is high.
- done rises the cycle after the last lane's NEXT.

## Structure
- Shared header holds the state encoding, TAP_W, and the lane-index width derivation.
- One natural sub-module, capture_pattern_check:
  - Lane mux, match counter, pass/fail pulse.
  - Ports: clk, rst, en, data[1:0], expect[1:0], pass, fail.
- The FSM, window registers and tap table stay in the top module.

## Test plan
- Lane 0 passes taps 10–20, other lanes pass 5–25:
  - Lane 0: 21 inc pulses, then 6 dec, tap_rd=15.
  - Other lanes: tap_rd=15.
  - fail_mask=0.
- Lane 3 never matches → 31 inc pulses on lane 3, fail_mask=7'b0001000, remaining lanes trained normally.
- Lane 2 passes taps 28–31 → no fail tap; stops at 31 with window 28..31 (width 4=MIN_WIN), centre 29, 2 dec pulses.
- Lane 1 passes taps 8–10 only → width 3<MIN_WIN, fail_mask[1]=1, tap_rd=11.
- A single mismatch injected at sample 40 of an otherwise passing tap → that tap fails and the window closes at the previous tap.
- rst mid-CENTER → next cycle busy=0, dly_ce=0, done=0. A new start gives a dly_rst pulse and a full rerun with identical final taps.

Source files
------------

// File: rtl/capture_align_ctrl_pkg.sv
// Shared constants and state encoding for the capture alignment controller.
package capture_align_ctrl_pkg;

    localparam int WIDTH     = 7;    // LVDS data lanes
    localparam int TAPS      = 32;   // IDELAY taps per lane
    localparam int SETTLE    = 16;   // idle cycles after a delay change
    localparam int CHECK_LEN = 64;   // consecutive matches for a passing tap
    localparam int MIN_WIN   = 4;    // narrowest acceptable window, in taps

    localparam int TAP_W  = $clog2(TAPS);
    localparam int LANE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SET_W  = $clog2(SETTLE + 1);
    localparam int CHK_W  = (CHECK_LEN > 1) ? $clog2(CHECK_LEN) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRST,
        ST_SETTLE,
        ST_CHECK,
        ST_STEP,
        ST_CENTER,
        ST_NEXT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/capture_align_ctrl_check.sv
// Per-tap pattern checker: counts consecutive matches of one lane's two bits.
// pass pulses on the CHECK_LEN-th consecutive match, fail on the first miss.
module capture_pattern_check
    import capture_align_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] data,
    input  logic [1:0] exp_data,
    output logic       pass,
    output logic       fail
);

    localparam logic [CHK_W-1:0] CHK_LAST = CHK_W'(CHECK_LEN - 1);

    logic [CHK_W-1:0] cnt_q, cnt_d;
    logic             match;

    // Compare sample, raise pass/fail, advance or clear the run counter.
    always_comb begin
        match = (data == exp_data);
        pass  = en && match && (cnt_q == CHK_LAST);
        fail  = en && !match;
        cnt_d = '0;
        if (en && match && !pass) begin
            cnt_d = cnt_q + CHK_W'(1);
        end
    end

    // Match-run counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/capture_align_ctrl.sv
// Per-lane IDELAY training: sweep taps, find the first passing window,
// park each lane at the window centre.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// DRST   | dly_rst pulse, all lanes back to tap 0
// SETTLE | wait for the delay line and capture pipeline, then go to ret_q
// CHECK  | compare the current lane against the pattern at tap cur
// STEP   | one dly_ce pulse (direction in dly_inc), cur moves by one
// CENTER | evaluate the window, walk back one tap at a time to the centre
// NEXT   | store result, move to the next lane at tap 0
// DONE   | run complete, results held until the next start
module capture_align_ctrl
    import capture_align_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   pattern,
    input  logic [2*WIDTH-1:0]   cap_data,
    output logic                 dly_rst,
    output logic [WIDTH-1:0]     dly_ce,
    output logic                 dly_inc,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     fail_mask,
    input  logic [LANE_W-1:0]    tap_rd_lane,
    output logic [TAP_W-1:0]     tap_rd
);

    localparam logic [TAP_W-1:0]  TAP_MAX     = TAP_W'(TAPS - 1);
    localparam logic [LANE_W-1:0] LANE_MAX    = LANE_W'(WIDTH - 1);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE);

    state_e              state_q, state_d;
    state_e              ret_q, ret_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [TAP_W-1:0]    cur_q, cur_d;
    logic [TAP_W-1:0]    first_q, first_d;
    logic [TAP_W-1:0]    last_q, last_d;
    logic                have_pass_q, have_pass_d;
    logic [SET_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic [WIDTH-1:0]    fail_mask_q, fail_mask_d;
    logic [TAP_W-1:0]    tap_tbl_q [WIDTH];
    logic [TAP_W-1:0]    tap_tbl_d [WIDTH];
    logic                dly_rst_q, dly_rst_d;
    logic [WIDTH-1:0]    dly_ce_q, dly_ce_d;
    logic                dly_inc_q, dly_inc_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                chk_en, chk_pass, chk_fail;
    logic [1:0]          lane_data, lane_exp;
    logic [TAP_W:0]      win_w, win_sum;
    logic [TAP_W-1:0]    centre;
    logic                sweep_end;

    assign lane_data = cap_data[{lane_q, 1'b0} +: 2];
    assign lane_exp  = pattern[{lane_q, 1'b0} +: 2];

    capture_pattern_check u_check (
        .clk      (clk),
        .rst      (rst),
        .en       (chk_en),
        .data     (lane_data),
        .exp_data (lane_exp),
        .pass     (chk_pass),
        .fail     (chk_fail)
    );

    // Window width and floor centre, one bit wider so 0..TAPS-1 cannot wrap.
    always_comb begin
        win_w   = {1'b0, last_q} - {1'b0, first_q} + (TAP_W + 1)'(1);
        win_sum = {1'b0, first_q} + {1'b0, last_q};
        centre  = win_sum[TAP_W:1];
    end

    // Next-state logic for the sweep/centre sequencer and its datapath.
    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        lane_d       = lane_q;
        cur_d        = cur_q;
        first_d      = first_q;
        last_d       = last_q;
        have_pass_d  = have_pass_q;
        settle_cnt_d = '0;
        fail_mask_d  = fail_mask_q;
        tap_tbl_d    = tap_tbl_q;
        dly_inc_d    = dly_inc_q;
        chk_en       = 1'b0;
        sweep_end    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_DRST;
                    fail_mask_d = '0;
                    tap_tbl_d   = '{default: '0};
                    lane_d      = '0;
                    cur_d       = '0;
                    first_d     = '0;
                    last_d      = '0;
                    have_pass_d = 1'b0;
                end
            end
            ST_DRST: begin
                state_d = ST_SETTLE;
                ret_d   = ST_CHECK;
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = ret_q;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
                end
            end
            ST_CHECK: begin
                chk_en = 1'b1;
                if (chk_pass || chk_fail) begin
                    if (chk_pass) begin
                        if (!have_pass_q) begin
                            first_d = cur_q;
                        end
                        last_d      = cur_q;
                        have_pass_d = 1'b1;
                    end
                    // A miss after any pass closes the window.
                    sweep_end = (chk_fail && have_pass_q) || (cur_q == TAP_MAX);
                    if (sweep_end) begin
                        state_d = ST_CENTER;
                    end else begin
                        state_d   = ST_STEP;
                        dly_inc_d = 1'b1;
                    end
                end
            end
            ST_STEP: begin
                cur_d   = dly_inc_q ? (cur_q + TAP_W'(1)) : (cur_q - TAP_W'(1));
                state_d = ST_SETTLE;
                ret_d   = dly_inc_q ? ST_CHECK : ST_CENTER;
            end
            ST_CENTER: begin
                if (!have_pass_q || (win_w < (TAP_W + 1)'(MIN_WIN))) begin
                    fail_mask_d[lane_q] = 1'b1;
                    tap_tbl_d[lane_q]   = cur_q;
                    state_d             = ST_NEXT;
                end else if (cur_q > centre) begin
                    state_d   = ST_STEP;
                    dly_inc_d = 1'b0;
                end else begin
                    tap_tbl_d[lane_q] = centre;
                    state_d           = ST_NEXT;
                end
            end
            ST_NEXT: begin
                cur_d       = '0;
                first_d     = '0;
                last_d      = '0;
                have_pass_d = 1'b0;
                if (lane_q == LANE_MAX) begin
                    state_d = ST_DONE;
                end else begin
                    lane_d  = lane_q + LANE_W'(1);
                    state_d = ST_CHECK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        dly_rst_d = (state_d == ST_DRST);
        dly_ce_d  = (state_d == ST_STEP) ? (WIDTH'(1) << lane_d) : '0;
        busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d    = (state_d == ST_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ret_q        <= ST_CHECK;
            lane_q       <= '0;
            cur_q        <= '0;
            first_q      <= '0;
            last_q       <= '0;
            have_pass_q  <= 1'b0;
            settle_cnt_q <= '0;
            fail_mask_q  <= '0;
            tap_tbl_q    <= '{default: '0};
            dly_rst_q    <= 1'b0;
            dly_ce_q     <= '0;
            dly_inc_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            lane_q       <= lane_d;
            cur_q        <= cur_d;
            first_q      <= first_d;
            last_q       <= last_d;
            have_pass_q  <= have_pass_d;
            settle_cnt_q <= settle_cnt_d;
            fail_mask_q  <= fail_mask_d;
            tap_tbl_q    <= tap_tbl_d;
            dly_rst_q    <= dly_rst_d;
            dly_ce_q     <= dly_ce_d;
            dly_inc_q    <= dly_inc_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Tap table readback; out-of-range lane selects read as 0.
    always_comb begin
        tap_rd = '0;
        if ({1'b0, tap_rd_lane} < (LANE_W + 1)'(WIDTH)) begin
            tap_rd = tap_tbl_q[tap_rd_lane];
        end
    end

    assign dly_rst   = dly_rst_q;
    assign dly_ce    = dly_ce_q;
    assign dly_inc   = dly_inc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail_mask = fail_mask_q;

endmodule
